mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one word-wide memory port between instruction fetch (IF) and load/store (LS) requesters.
// Converts byte addresses, sizes and sign flags into memory word address, byte enables and lane-aligned data.
// The memory port writes the whole word with unselected lanes zeroed, so sub-word stores are done as read-modify-write.
// Sits between the core pipeline and the memory macro.
// PARAMETERS
// AW        8  memory word-address width; byte address width is AW+2
// ARB_MODE  0  0 = round-robin between IF and LS; 1 = LS fixed priority over IF
// PORTS
// clk          in   1     core clock
// rst          in   1     synchronous reset, active-high
// if_req       in   1     fetch request, held until accepted
// if_addr      in   AW+2  fetch byte address; bits[1:0] ignored
// if_ready     out  1     fetch accepted this cycle
// if_rvalid    out  1     one-cycle pulse: if_rdata valid
// if_rdata     out  32    fetched word
// ls_req       in   1     load/store request, held until accepted
// ls_we        in   1     1 = store, 0 = load
// ls_addr      in   AW+2  byte address
// ls_size      in   2     00 = byte, 01 = half, 10 = word, 11 = illegal
// ls_unsigned  in   1     load zero-extend (1) / sign-extend (0)
// ls_wdata     in   32    store data, right-aligned
// ls_ready     out  1     LS request accepted this cycle
// ls_rvalid    out  1     one-cycle completion pulse for loads and stores
// ls_rdata     out  32    load result, extended; 0 for stores and errors
// ls_err       out  1     valid with ls_rvalid: misaligned or illegal request
// mem_we       out  1     memory write enable (memory writes on falling clk)
// mem_addr     out  AW    memory word address
// mem_byteen   out  4     memory byte enables
// mem_din      out  32    memory write data
// mem_dout     in   32    memory read data, combinational, masked by mem_byteen
// BEHAVIOUR
// - FSM states: IDLE, RD, WR. Requests are latched on acceptance: addr, we, size, unsigned, wdata, owner.
// - Acceptance happens in IDLE only. Winner selection:
//   - one requester: that requester wins;
//   - both, ARB_MODE=0: the one not served last wins; last-served resets to LS, so IF wins first;
//   - both, ARB_MODE=1: LS wins.
// - ready is combinational: high for the winner only, in IDLE only. The rising edge with req&&ready is acceptance.
// - Error check (LS): size 11, half with addr[0]=1, or word with addr[1:0]!=0.
//   - Erroneous requests are accepted but cause no memory access and the FSM stays IDLE.
//   - Next cycle: ls_rvalid=1, ls_err=1, ls_rdata=0.
// - Transitions:
//   - IDLE -> RD: fetch, load, byte store, half store.
//   - IDLE -> WR: word store.
//   - RD -> WR: sub-word store. RD -> IDLE: otherwise.
//   - WR -> IDLE.
// - RD cycle:
//   - mem_addr = latched addr[AW+1:2], mem_byteen = 1111, mem_we = 0.
//   - mem_dout is captured at the closing edge: into the load result, or into the merge buffer for a store.
//   - Merge: the selected lanes are replaced by the store data; the other lanes are kept.
// - WR cycle: mem_we = 1, mem_byteen = 1111, mem_din = merged word (word store: ls_wdata).
// - Outside RD/WR: mem_we = 0, mem_byteen = 0000, mem_addr = 0, mem_din = 0.
// - Load extraction:
//   - byte k = addr[1:0]: dout[8k+7:8k];
//   - half h = addr[1]: dout[16h+15:16h];
//   - the result is zero- or sign-extended per ls_unsigned.
// - Latency from acceptance edge E0 to the rvalid pulse:
//   - fetch, load, word store: rvalid high during cycle E1..E2;
//   - sub-word store: rvalid high during cycle E2..E3;
//   - error: rvalid high during cycle E0..E1.
// - rvalid goes only to the owner of the latched request and lasts exactly one cycle.
// - rdata holds its value until the next response for the same requester.
// - A new acceptance is allowed in the same cycle as an rvalid pulse (back-to-back = one access per 2 cycles).
// - Reset (rst high at an edge):
//   - state -> IDLE;
//   - if_rvalid, ls_rvalid, ls_err, if_rdata, ls_rdata -> 0; mem_* outputs -> 0;
//   - last-served -> LS; the pending request is dropped with no response.
// - A WR cycle already in progress when rst rises still completes its falling-edge write.
// - Reset during RD prevents the write.
// TESTING
// - sw 0xDEADBEEF @0x010, then lw @0x010 -> store: mem_we high 1 cycle at mem_addr 0x04; load rdata 0xDEADBEEF, rvalid at E0+1.
// - sb 0x80 @0x011 over 0xDEADBEEF -> RD then WR, mem_din 0xDEAD80EF; lb @0x011 -> 0xFFFFFF80; lbu -> 0x00000080.
// - sh 0xABCD @0x012 over 0xDEAD80EF -> memory 0xABCD80EF; lh @0x012 -> 0xFFFFABCD; rvalid at E0+2.
// - if_req and ls_req held high for 6 accesses, ARB_MODE=0 -> grants IF,LS,IF,LS,IF,LS; ARB_MODE=1 -> all LS, IF starved.
// - lh @0x013, lw @0x012, size 11 -> each: ls_err=1, ls_rvalid=1 next cycle, ls_rdata=0, mem_we never asserted.
// - rst pulsed during RD of sb -> memory unchanged, no ls_rvalid, ls_ready high the cycle after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LS arbiter onto one word-wide memory port
// Sub-word stores are read-modify-write: RD fetches the word, WR writes the merged word.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int ARB_MODE = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW+1:0] if_addr_i,
  output logic          if_ready_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [AW+1:0] ls_addr_i,
  input  logic [1:0]    ls_size_i,
  input  logic          ls_unsigned_i,
  input  logic [31:0]   ls_wdata_i,
  output logic          ls_ready_o,
  output logic          ls_rvalid_o,
  output logic [31:0]   ls_rdata_o,
  output logic          ls_err_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_byteen_o,
  output logic [31:0]   mem_din_o,
  input  logic [31:0]   mem_dout_i
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

  state_e        state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          own_ls_q, own_ls_d;
  logic          last_ls_q, last_ls_d;
  logic [31:0]   merge_q, merge_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic          ls_err_q, ls_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;

  logic          grant_if, grant_ls;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  function automatic logic ls_bad(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00);
  endfunction

  // Round-robin remembers the last served requester; mode 1 always favours LS.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == S_IDLE) begin
      if (if_req_i && ls_req_i) begin
        if (ARB_MODE == 1 || !last_ls_q) grant_ls = 1'b1;
        else                             grant_if = 1'b1;
      end else begin
        grant_if = if_req_i;
        grant_ls = ls_req_i;
      end
    end
  end

  assign if_ready_o = grant_if;
  assign ls_ready_o = grant_ls;

  always_comb begin
    ld_byte = mem_dout_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_dout_i[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   load_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: load_val = mem_dout_i;
    endcase
  end

  always_comb begin
    merged = mem_dout_i;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    own_ls_d     = own_ls_q;
    last_ls_d    = last_ls_q;
    merge_d      = merge_q;
    if_rvalid_d  = 1'b0;
    ls_rvalid_d  = 1'b0;
    ls_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_byteen_o = 4'b0000;
    mem_din_o    = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_if) begin
          addr_d    = if_addr_i;
          we_d      = 1'b0;
          size_d    = 2'b10;
          uns_d     = 1'b0;
          wdata_d   = 32'h0;
          own_ls_d  = 1'b0;
          last_ls_d = 1'b0;
          state_d   = S_RD;
        end else if (grant_ls) begin
          addr_d    = ls_addr_i;
          we_d      = ls_we_i;
          size_d    = ls_size_i;
          uns_d     = ls_unsigned_i;
          wdata_d   = ls_wdata_i;
          own_ls_d  = 1'b1;
          last_ls_d = 1'b1;
          // Bad requests are answered straight from IDLE without touching memory.
          if (ls_bad(ls_size_i, ls_addr_i[1:0])) begin
            ls_rvalid_d = 1'b1;
            ls_err_d    = 1'b1;
            ls_rdata_d  = 32'h0;
          end else if (ls_we_i && ls_size_i == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        mem_addr_o   = addr_q[AW+1:2];
        mem_byteen_o = 4'b1111;
        if (we_q) begin
          merge_d = merged;
          state_d = S_WR;
        end else begin
          state_d = S_IDLE;
          if (own_ls_q) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = load_val;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_dout_i;
          end
        end
      end
      S_WR: begin
        mem_we_o     = 1'b1;
        mem_addr_o   = addr_q[AW+1:2];
        mem_byteen_o = 4'b1111;
        mem_din_o    = (size_q == 2'b10) ? wdata_q : merge_q;
        state_d      = S_IDLE;
        ls_rvalid_d  = 1'b1;
        ls_rdata_d   = 32'h0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
      own_ls_q    <= 1'b0;
      last_ls_q   <= 1'b1;
      merge_q     <= 32'h0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      ls_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      own_ls_q    <= own_ls_d;
      last_ls_q   <= last_ls_d;
      merge_q     <= merge_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_err_q    <= ls_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_err_o    = ls_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and random checks of mem_port_arbiter against a byte-level memory model
module tb_mem_port_arbiter;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req, ls_req, ls_we, ls_uns;
  logic [AW+1:0] if_addr, ls_addr;
  logic [1:0]    ls_size;
  logic [31:0]   ls_wdata;

  logic          if_ready0, if_rvalid0, ls_ready0, ls_rvalid0, ls_err0, mem_we0;
  logic [31:0]   if_rdata0, ls_rdata0, mem_din0, mem_dout0;
  logic [AW-1:0] mem_addr0;
  logic [3:0]    mem_be0;
  logic          if_ready1, if_rvalid1, ls_ready1, ls_rvalid1, ls_err1, mem_we1;
  logic [31:0]   if_rdata1, ls_rdata1, mem_din1, mem_dout1;
  logic [AW-1:0] mem_addr1;
  logic [3:0]    mem_be1;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] ref_mem [256];
  int wr_cnt0 = 0;
  int wr_cnt1 = 0;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign mem_dout0 = mem0[mem_addr0] & be_mask(mem_be0);
  assign mem_dout1 = mem1[mem_addr1] & be_mask(mem_be1);

  always @(negedge clk) begin
    if (mem_we0) begin mem0[mem_addr0] = mem_din0 & be_mask(mem_be0); wr_cnt0++; end
    if (mem_we1) begin mem1[mem_addr1] = mem_din1 & be_mask(mem_be1); wr_cnt1++; end
  end

  mem_port_arbiter #(.AW(AW), .ARB_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready0),
    .if_rvalid_o(if_rvalid0), .if_rdata_o(if_rdata0),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_size_i(ls_size),
    .ls_unsigned_i(ls_uns), .ls_wdata_i(ls_wdata), .ls_ready_o(ls_ready0),
    .ls_rvalid_o(ls_rvalid0), .ls_rdata_o(ls_rdata0), .ls_err_o(ls_err0),
    .mem_we_o(mem_we0), .mem_addr_o(mem_addr0), .mem_byteen_o(mem_be0),
    .mem_din_o(mem_din0), .mem_dout_i(mem_dout0));

  mem_port_arbiter #(.AW(AW), .ARB_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready1),
    .if_rvalid_o(if_rvalid1), .if_rdata_o(if_rdata1),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_size_i(ls_size),
    .ls_unsigned_i(ls_uns), .ls_wdata_i(ls_wdata), .ls_ready_o(ls_ready1),
    .ls_rvalid_o(ls_rvalid1), .ls_rdata_o(ls_rdata1), .ls_err_o(ls_err1),
    .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_byteen_o(mem_be1),
    .mem_din_o(mem_din1), .mem_dout_i(mem_dout1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: an access of 2**size bytes must be naturally aligned; size 3 is never legal.
  function automatic bit ref_err(input logic [AW+1:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || ((int'(a) % (1 << sz)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [AW+1:0] a, input logic [1:0] sz, input bit uns);
    longint w, v, full;
    int nb, sh;
    nb   = 1 << sz;
    sh   = 8 * (int'(a) % 4);
    full = longint'(1) << (8 * nb);
    w    = longint'(ref_mem[a[AW+1:2]]);
    v    = (w >> sh) & (full - 1);
    if (!uns && v >= (full >> 1)) v = v - full;
    return v[31:0];
  endfunction

  task automatic do_ls(input string tag, input bit we, input logic [AW+1:0] a,
                       input logic [1:0] sz, input bit uns, input logic [31:0] wd);
    int n, lat, w0, exp_lat, nb, off, wi;
    bit err;
    logic [31:0] exp_rd;
    err = ref_err(a, sz);
    wi  = int'(a[AW+1:2]);
    if (err) begin
      exp_lat = 0; exp_rd = 32'h0;
    end else if (we) begin
      exp_lat = (sz == 2'd2) ? 1 : 2; exp_rd = 32'h0;
      nb = 1 << sz; off = int'(a) % 4;
      for (int k = 0; k < nb; k++) ref_mem[wi][8*(off+k) +: 8] = wd[8*k +: 8];
    end else begin
      exp_lat = 1; exp_rd = ref_load(a, sz, uns);
    end
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_size = sz; ls_uns = uns; ls_wdata = wd;
    n = 0;
    #1;
    while (!ls_ready0 && n < 20) begin @(posedge clk); #2; n++; end
    chk({tag, " ready"}, 32'(ls_ready0), 32'd1);
    w0 = wr_cnt0;
    @(posedge clk); #1;
    ls_req = 1'b0;
    lat = 0;
    while (!ls_rvalid0 && lat < 8) begin @(posedge clk); #1; lat++; end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " err"}, 32'(ls_err0), 32'(err));
    chk({tag, " rdata"}, ls_rdata0, exp_rd);
    chk({tag, " if_rvalid"}, 32'(if_rvalid0), 32'd0);
    chk({tag, " writes"}, 32'(wr_cnt0 - w0), (we && !err) ? 32'd1 : 32'd0);
  endtask

  task automatic do_if(input string tag, input logic [AW+1:0] a);
    int n, lat;
    logic [31:0] exp_rd;
    exp_rd = ref_mem[a[AW+1:2]];
    if_req = 1'b1; if_addr = a;
    n = 0;
    #1;
    while (!if_ready0 && n < 20) begin @(posedge clk); #2; n++; end
    chk({tag, " ready"}, 32'(if_ready0), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    lat = 0;
    while (!if_rvalid0 && lat < 8) begin @(posedge clk); #1; lat++; end
    chk({tag, " latency"}, 32'(lat), 32'd1);
    chk({tag, " rdata"}, if_rdata0, exp_rd);
    chk({tag, " ls_rvalid"}, 32'(ls_rvalid0), 32'd0);
  endtask

  initial begin
    int w0, g0n, g1n, cyc;
    int g0 [6];
    int g1 [6];
    bit last_ls;
    logic [31:0] r;
    logic [AW+1:0] ra;

    for (int i = 0; i < 256; i++) begin
      r = $urandom; mem0[i] = r; mem1[i] = r; ref_mem[i] = r;
    end
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_uns = 1'b0;
    if_addr = '0; ls_addr = '0; ls_size = 2'd0; ls_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst if_rvalid", 32'(if_rvalid0), 32'd0);
    chk("rst ls_rvalid", 32'(ls_rvalid0), 32'd0);
    chk("rst ls_err", 32'(ls_err0), 32'd0);
    chk("rst if_rdata", if_rdata0, 32'h0);
    chk("rst ls_rdata", ls_rdata0, 32'h0);
    chk("rst mem_we", 32'(mem_we0), 32'd0);
    chk("rst mem_addr", 32'(mem_addr0), 32'd0);
    chk("rst mem_byteen", 32'(mem_be0), 32'd0);
    chk("rst mem_din", mem_din0, 32'h0);
    chk("rst ready idle", 32'(ls_ready0 | if_ready0), 32'd0);

    do_ls("sw", 1'b1, 10'h010, 2'd2, 1'b0, 32'hDEADBEEF);
    chk("sw mem word4", mem0[4], 32'hDEADBEEF);
    do_ls("lw", 1'b0, 10'h010, 2'd2, 1'b0, 32'h0);
    chk("lw value", ls_rdata0, 32'hDEADBEEF);
    do_ls("sb", 1'b1, 10'h011, 2'd0, 1'b0, 32'h00000080);
    chk("sb mem word4", mem0[4], 32'hDEAD80EF);
    do_ls("lb", 1'b0, 10'h011, 2'd0, 1'b0, 32'h0);
    chk("lb value", ls_rdata0, 32'hFFFFFF80);
    do_ls("lbu", 1'b0, 10'h011, 2'd0, 1'b1, 32'h0);
    chk("lbu value", ls_rdata0, 32'h00000080);
    do_ls("sh", 1'b1, 10'h012, 2'd1, 1'b0, 32'h0000ABCD);
    chk("sh mem word4", mem0[4], 32'hABCD80EF);
    do_ls("lh", 1'b0, 10'h012, 2'd1, 1'b0, 32'h0);
    chk("lh value", ls_rdata0, 32'hFFFFABCD);
    do_if("fetch", 10'h010);
    chk("ls_rdata hold", ls_rdata0, 32'hFFFFABCD);
    do_ls("lh mis", 1'b0, 10'h013, 2'd1, 1'b0, 32'h0);
    do_ls("lw mis", 1'b0, 10'h012, 2'd2, 1'b0, 32'h0);
    do_ls("size11", 1'b0, 10'h010, 2'd3, 1'b0, 32'h0);
    do_ls("sw mis", 1'b1, 10'h011, 2'd2, 1'b0, 32'h12345678);
    chk("err mem word4", mem0[4], 32'hABCD80EF);

    // Reset lands on the edge that closes the RD cycle of a byte store.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 10'h011; ls_size = 2'd0; ls_uns = 1'b0; ls_wdata = 32'h55;
    #1 chk("rst-sb ready", 32'(ls_ready0), 32'd1);
    w0 = wr_cnt0;
    @(posedge clk); #1;
    ls_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst-sb no rvalid", 32'(ls_rvalid0), 32'd0);
    chk("rst-sb mem_we", 32'(mem_we0), 32'd0);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h010; ls_size = 2'd2;
    #1 chk("rst-sb ready after", 32'(ls_ready0), 32'd1);
    do_ls("rst-sb lw", 1'b0, 10'h010, 2'd2, 1'b0, 32'h0);
    chk("rst-sb no write", 32'(wr_cnt0 - w0), 32'd0);
    chk("rst-sb mem word4", mem0[4], 32'hABCD80EF);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin g0[k] = 2; g1[k] = 2; end
    if_req = 1'b1; if_addr = 10'h010;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h010; ls_size = 2'd2; ls_uns = 1'b0;
    g0n = 0; g1n = 0; cyc = 0;
    while ((g0n < 6 || g1n < 6) && cyc < 40) begin
      #1;
      if (g0n < 6 && (if_ready0 || ls_ready0)) begin g0[g0n] = int'(ls_ready0); g0n++; end
      if (g1n < 6 && (if_ready1 || ls_ready1)) begin g1[g1n] = int'(ls_ready1); g1n++; end
      @(posedge clk); #1;
      cyc++;
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("arb0 grants", 32'(g0n), 32'd6);
    chk("arb1 grants", 32'(g1n), 32'd6);
    last_ls = 1'b1;
    for (int k = 0; k < 6; k++) begin
      last_ls = !last_ls;
      chk($sformatf("arb0 grant%0d is_ls", k), 32'(g0[k]), 32'(last_ls));
      chk($sformatf("arb1 grant%0d is_ls", k), 32'(g1[k]), 32'd1);
    end
    repeat (4) @(posedge clk);
    #1;

    for (int t = 0; t < 60; t++) begin
      ra = {AW'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 4) == 0)
        do_if($sformatf("rnd%0d if", t), {ra[AW+1:2], 2'b00});
      else
        do_ls($sformatf("rnd%0d ls", t), 1'($urandom), ra, 2'($urandom), 1'($urandom), $urandom);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("final word%0d", i), mem0[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
